// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID/EX stage: control bundle layout and opcodes.
package mips_pkg;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    BEQ   = 6'h04,
    ADDI  = 6'h08,
    SLTI  = 6'h0A,
    ANDI  = 6'h0C,
    ORI   = 6'h0D,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_e;

  // rt is a source when the ALU takes it as operand B, or when a store writes it to memory.
  function automatic logic uses_rt(input logic [EX_W-1:0] ex_ctl, input logic [M_W-1:0] m_ctl);
    return ~ex_ctl[EX_ALUSRC] | m_ctl[M_MEMWRITE];
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detector: compares the load in EX against the sources of the ID instruction.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [M_W-1:0]    ex_m_ctl,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [EX_W-1:0]   id_ex_ctl,
  input  logic [M_W-1:0]    id_m_ctl,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  output logic              stall
);

  logic hazard;

  always_comb begin
    hazard = ex_m_ctl[M_MEMREAD] & ex_valid & id_valid &
             (ex_rt != {REG_AW{1'b0}}) &
             ((ex_rt == id_rs) | (uses_rt(id_ex_ctl, id_m_ctl) & (ex_rt == id_rt)));
    // A squashed instruction never needs to wait for its operands.
    stall  = hazard & ~flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch-flush bubbles and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [EX_W-1:0]   id_ex_ctl,
  input  logic [M_W-1:0]    id_m_ctl,
  input  logic [WB_W-1:0]   id_wb_ctl,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc4,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rt_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [EX_W-1:0]   ex_ex_ctl,
  output logic [M_W-1:0]    ex_m_ctl,
  output logic [WB_W-1:0]   ex_wb_ctl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [XLEN-1:0]   ex_rs_data,
  output logic [XLEN-1:0]   ex_rt_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [EX_W-1:0]   ex_ctl_q, ex_ctl_d;
  logic [M_W-1:0]    m_ctl_q,  m_ctl_d;
  logic [WB_W-1:0]   wb_ctl_q, wb_ctl_d;
  logic              valid_q,  valid_d;
  logic [XLEN-1:0]   pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bubble;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .ex_m_ctl  (m_ctl_q),
    .ex_valid  (valid_q),
    .ex_rt     (rt_q),
    .id_ex_ctl (id_ex_ctl),
    .id_m_ctl  (id_m_ctl),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .flush     (flush),
    .stall     (stall)
  );

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign bubble     = stall | flush;

  // Next-state for control bundles, valid and the bubble counter.
  always_comb begin
    ex_ctl_d = {EX_W{1'b0}};
    m_ctl_d  = {M_W{1'b0}};
    wb_ctl_d = {WB_W{1'b0}};
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    if (bubble || !id_valid) begin
      ex_ctl_d = {EX_W{1'b0}};
      m_ctl_d  = {M_W{1'b0}};
      wb_ctl_d = {WB_W{1'b0}};
      valid_d  = 1'b0;
    end else begin
      ex_ctl_d = id_ex_ctl;
      m_ctl_d  = id_m_ctl;
      wb_ctl_d = id_wb_ctl;
      valid_d  = 1'b1;
    end
    if (bubble && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline register bank; datapath fields load every cycle, even during a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctl_q  <= {EX_W{1'b0}};
      m_ctl_q   <= {M_W{1'b0}};
      wb_ctl_q  <= {WB_W{1'b0}};
      valid_q   <= 1'b0;
      pc4_q     <= {XLEN{1'b0}};
      rs_data_q <= {XLEN{1'b0}};
      rt_data_q <= {XLEN{1'b0}};
      imm_q     <= {XLEN{1'b0}};
      rs_q      <= {REG_AW{1'b0}};
      rt_q      <= {REG_AW{1'b0}};
      rd_q      <= {REG_AW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      ex_ctl_q  <= ex_ctl_d;
      m_ctl_q   <= m_ctl_d;
      wb_ctl_q  <= wb_ctl_d;
      valid_q   <= valid_d;
      pc4_q     <= id_pc4;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_ex_ctl  = ex_ctl_q;
  assign ex_m_ctl   = m_ctl_q;
  assign ex_wb_ctl  = wb_ctl_q;
  assign ex_valid   = valid_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with a 4-bit bubble counter.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        id_ex_ctl;
  logic [2:0]        id_m_ctl;
  logic [1:0]        id_wb_ctl;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              flush;
  logic              stall, pc_write, ifid_write;
  logic [3:0]        ex_ex_ctl;
  logic [2:0]        ex_m_ctl;
  logic [1:0]        ex_wb_ctl;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_ctl(id_ex_ctl), .id_m_ctl(id_m_ctl), .id_wb_ctl(id_wb_ctl), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_ex_ctl(ex_ex_ctl), .ex_m_ctl(ex_m_ctl), .ex_wb_ctl(ex_wb_ctl), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_ex_ctl  = ex;
    id_m_ctl   = m;
    id_wb_ctl  = wb;
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_pc4     = id_pc4 + 32'd4;
    id_rs_data = {27'd0, rs};
    id_rt_data = {27'd0, rt};
    id_imm     = 32'h0000_0010;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_lw(input logic [4:0] rt);
    set_id(4'b0001, 3'b010, 2'b11, 5'd2, rt, 5'd0);
    step();
  endtask

  task automatic count_bubble();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_ex_ctl = 4'd0; id_m_ctl = 3'd0; id_wb_ctl = 2'd0;
    id_pc4 = 32'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_ex_ctl", ex_ex_ctl, 64'd0);
    check_vec("rst_m_ctl", ex_m_ctl, 64'd0);
    check_vec("rst_valid", ex_valid, 64'd0);
    check_vec("rst_cnt", bubble_cnt, 64'd0);
    check_vec("rst_stall", stall, 64'd0);
    check_vec("rst_pc_write", pc_write, 64'd1);
    rst_n = 1'b1;
    step();
    check_vec("post_rst_pc4", ex_pc4, 64'd0);

    // lw $8 then dependent add rs=8
    issue_lw(5'd8);
    check_vec("lw_m_ctl", ex_m_ctl, 64'h2);
    check_vec("lw_rt", ex_rt, 64'd8);
    set_id(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    check_vec("dep_stall", stall, 64'd1);
    check_vec("dep_ifid_write", ifid_write, 64'd0);
    step(); count_bubble();
    check_vec("bubble_ex_ctl", ex_ex_ctl, 64'd0);
    check_vec("bubble_m_ctl", ex_m_ctl, 64'd0);
    check_vec("bubble_wb_ctl", ex_wb_ctl, 64'd0);
    check_vec("bubble_valid", ex_valid, 64'd0);
    check_vec("bubble_cnt1", bubble_cnt, 64'd1);
    check_vec("stall_one_cycle", stall, 64'd0);
    step();
    check_vec("add_ex_ctl", ex_ex_ctl, 64'hC);
    check_vec("add_wb_ctl", ex_wb_ctl, 64'h2);
    check_vec("add_valid", ex_valid, 64'd1);
    check_vec("add_rd", ex_rd, 64'd10);
    check_vec("add_cnt", bubble_cnt, 64'd1);

    // lw rt=8 then addi rs=3 rt=8 (rt is destination)
    issue_lw(5'd8);
    set_id(4'b0001, 3'b000, 2'b10, 5'd3, 5'd8, 5'd0);
    check_vec("addi_no_stall", stall, 64'd0);
    step();
    check_vec("addi_valid", ex_valid, 64'd1);
    check_vec("addi_cnt", bubble_cnt, 64'd1);

    // lw rt=0 then add rs=0
    issue_lw(5'd0);
    set_id(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd4);
    check_vec("zero_reg_no_stall", stall, 64'd0);
    step();

    // back-to-back independent loads
    issue_lw(5'd8);
    set_id(4'b0001, 3'b010, 2'b11, 5'd3, 5'd9, 5'd0);
    check_vec("lw_lw_no_stall", stall, 64'd0);
    step();
    // independent instruction in between, then dependent: no stall
    set_id(4'b1100, 3'b000, 2'b10, 5'd4, 5'd5, 5'd6);
    check_vec("indep_no_stall", stall, 64'd0);
    step();
    set_id(4'b1100, 3'b000, 2'b10, 5'd9, 5'd5, 5'd7);
    check_vec("dist2_no_stall", stall, 64'd0);
    step();

    // store reads rt even with ALUSrc=1
    issue_lw(5'd8);
    set_id(4'b0001, 3'b001, 2'b00, 5'd3, 5'd8, 5'd0);
    check_vec("sw_rt_stall", stall, 64'd1);
    step(); count_bubble();
    check_vec("sw_bubble_cnt", bubble_cnt, exp_cnt[3:0]);

    // dependent add with flush in same cycle
    issue_lw(5'd8);
    set_id(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    flush = 1'b1;
    #1;
    check_vec("flush_no_stall", stall, 64'd0);
    check_vec("flush_pc_write", pc_write, 64'd1);
    step(); count_bubble();
    flush = 1'b0;
    check_vec("flush_bubble_valid", ex_valid, 64'd0);
    check_vec("flush_bubble_ctl", ex_ex_ctl, 64'd0);
    check_vec("flush_cnt_once", bubble_cnt, exp_cnt[3:0]);

    // 20 hazard cycles drive the counter to saturation
    for (int i = 0; i < 20; i++) begin
      issue_lw(5'd8);
      set_id(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
      step(); count_bubble();
    end
    check_vec("sat_cnt", bubble_cnt, 64'd15);
    check_vec("sat_model", exp_cnt, 64'd15);

    // reset asserted in the middle of a stall
    issue_lw(5'd8);
    set_id(4'b1100, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    check_vec("pre_rst_stall", stall, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_vec("midrst_stall", stall, 64'd0);
    check_vec("midrst_cnt", bubble_cnt, 64'd0);
    check_vec("midrst_m_ctl", ex_m_ctl, 64'd0);
    check_vec("midrst_valid", ex_valid, 64'd0);
    check_vec("midrst_rt", ex_rt, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
